// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encodings and helpers for the UART command receiver.
// Byte receiver and command parser both import this package.
package uart_cmd_pkg;

    localparam int DEFAULT_CLK_HZ = 50_000_000;
    localparam int DEFAULT_BAUD   = 115200;
    localparam int CLKS_PER_BIT   = DEFAULT_CLK_HZ / DEFAULT_BAUD;

    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_S    = 8'h53;
    localparam logic [7:0] ASCII_G    = 8'h47;
    localparam logic [7:0] ASCII_Q    = 8'h51;
    localparam logic [7:0] ASCII_CR   = 8'h0D;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_CMD,
        P_H1,
        P_H2,
        P_END
    } parse_state_t;

    typedef enum logic [1:0] {
        CMD_R,
        CMD_S,
        CMD_G,
        CMD_Q
    } cmd_t;

    // Returns {is_hex, nibble}; letters A-F and a-f share the same low nibble.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] res;
        res = 5'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            res = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            res = {1'b1, c[3:0] + 4'd9};
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_cmd_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchronizer, falling-edge start detect,
// mid-bit sampling, registered byte_valid / frame_err pulses.
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int BIT_CLKS = CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int CNT_W     = $clog2(BIT_CLKS);

    rx_state_t        state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic             rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    logic fall_edge;
    logic half_tick;
    logic bit_tick;

    assign fall_edge = rx_prev_q & ~rx_sync_q;
    assign half_tick = (cnt_q == CNT_W'(HALF_CLKS - 1));
    assign bit_tick  = (cnt_q == CNT_W'(BIT_CLKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (fall_edge) state_d = START;
            // A line back high at mid-start is a glitch, not a start bit.
            START: if (half_tick) state_d = rx_sync_q ? IDLE : DATA;
            DATA:  if (bit_tick && bit_idx_q == 3'd7) state_d = STOP;
            STOP:  if (bit_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_meta_d    = rx_pin;
        rx_sync_d    = rx_meta_q;
        rx_prev_d    = rx_sync_q;
        cnt_d        = cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
            end
            START: begin
                if (half_tick) cnt_d = '0;
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        data_d       = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data       = data_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: parses "#R\r", "#S\r", "#G\r" and "#Qhh\r" frames
// into counter control and quench-width configuration outputs.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int         CLK_HZ         = 50_000_000,
    parameter int         BAUD           = 115200,
    parameter logic [7:0] QUENCH_DEFAULT = 8'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic       clr_cnt,
    output logic       count_en,
    output logic [7:0] quench_cfg,
    output logic       quench_cfg_valid,
    output logic       cmd_err,
    output logic       frame_err
);

    localparam int BIT_CLKS = CLK_HZ / BAUD;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    uart_rx_byte #(
        .BIT_CLKS(BIT_CLKS)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_pin    (rx_pin),
        .data      (rx_data),
        .byte_valid(rx_valid),
        .frame_err (rx_frame_err)
    );

    parse_state_t pstate_q, pstate_d;
    cmd_t         cmd_q, cmd_d;
    logic [7:0]   hex_byte_q, hex_byte_d;
    logic         clr_cnt_q, clr_cnt_d;
    logic         count_en_q, count_en_d;
    logic [7:0]   quench_cfg_q, quench_cfg_d;
    logic         quench_cfg_valid_q, quench_cfg_valid_d;
    logic         cmd_err_q, cmd_err_d;

    logic [4:0] hex_dec;
    logic       is_hex;
    logic       is_hash;
    logic       is_rsg;

    assign hex_dec = hex_decode(rx_data);
    assign is_hex  = hex_dec[4];
    assign is_hash = (rx_data == ASCII_HASH);
    assign is_rsg  = (rx_data == ASCII_R) || (rx_data == ASCII_S) || (rx_data == ASCII_G);

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate_q <= P_IDLE;
        end else begin
            pstate_q <= pstate_d;
        end
    end

    always_comb begin
        pstate_d = pstate_q;
        if (rx_frame_err) begin
            pstate_d = P_IDLE;
        end else if (rx_valid) begin
            // '#' always restarts a frame, whatever was in progress.
            if (is_hash) begin
                pstate_d = P_CMD;
            end else begin
                case (pstate_q)
                    P_IDLE: pstate_d = P_IDLE;
                    P_CMD: begin
                        if (is_rsg)                    pstate_d = P_END;
                        else if (rx_data == ASCII_Q)   pstate_d = P_H1;
                        else                           pstate_d = P_IDLE;
                    end
                    P_H1:    pstate_d = is_hex ? P_H2 : P_IDLE;
                    P_H2:    pstate_d = is_hex ? P_END : P_IDLE;
                    P_END:   pstate_d = P_IDLE;
                    default: pstate_d = P_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        cmd_d              = cmd_q;
        hex_byte_d         = hex_byte_q;
        clr_cnt_d          = 1'b0;
        count_en_d         = count_en_q;
        quench_cfg_d       = quench_cfg_q;
        quench_cfg_valid_d = 1'b0;
        cmd_err_d          = 1'b0;
        if (rx_valid && !is_hash) begin
            case (pstate_q)
                P_CMD: begin
                    if (rx_data == ASCII_R)      cmd_d = CMD_R;
                    else if (rx_data == ASCII_S) cmd_d = CMD_S;
                    else if (rx_data == ASCII_G) cmd_d = CMD_G;
                    else if (rx_data == ASCII_Q) cmd_d = CMD_Q;
                    else                         cmd_err_d = 1'b1;
                end
                P_H1: begin
                    if (is_hex) hex_byte_d = {hex_dec[3:0], 4'h0};
                    else        cmd_err_d  = 1'b1;
                end
                P_H2: begin
                    if (is_hex) hex_byte_d = {hex_byte_q[7:4], hex_dec[3:0]};
                    else        cmd_err_d  = 1'b1;
                end
                P_END: begin
                    if (rx_data == ASCII_CR) begin
                        case (cmd_q)
                            CMD_R: clr_cnt_d  = 1'b1;
                            CMD_S: count_en_d = 1'b0;
                            CMD_G: count_en_d = 1'b1;
                            CMD_Q: begin
                                quench_cfg_d       = hex_byte_q;
                                quench_cfg_valid_d = 1'b1;
                            end
                            default: clr_cnt_d = 1'b0;
                        endcase
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                default: cmd_err_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q              <= CMD_R;
            hex_byte_q         <= 8'h00;
            clr_cnt_q          <= 1'b0;
            count_en_q         <= 1'b1;
            quench_cfg_q       <= QUENCH_DEFAULT;
            quench_cfg_valid_q <= 1'b0;
            cmd_err_q          <= 1'b0;
        end else begin
            cmd_q              <= cmd_d;
            hex_byte_q         <= hex_byte_d;
            clr_cnt_q          <= clr_cnt_d;
            count_en_q         <= count_en_d;
            quench_cfg_q       <= quench_cfg_d;
            quench_cfg_valid_q <= quench_cfg_valid_d;
            cmd_err_q          <= cmd_err_d;
        end
    end

    assign clr_cnt          = clr_cnt_q;
    assign count_en         = count_en_q;
    assign quench_cfg       = quench_cfg_q;
    assign quench_cfg_valid = quench_cfg_valid_q;
    assign cmd_err          = cmd_err_q;
    assign frame_err        = rx_frame_err;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: stimulus pushes expected output events,
// an independent monitor pops and compares them as the DUT produces them.
module tb_uart_cmd_rx;

    localparam int CLK_HZ   = 25_000_000;
    localparam int BAUD     = 115200;
    localparam int CPB      = CLK_HZ / BAUD;
    localparam int NOM      = (19 * CPB) / 2;
    localparam int IDLE_GAP = 20;

    localparam int EV_NONE = 0;
    localparam int EV_CLR  = 1;
    localparam int EV_QCFG = 2;
    localparam int EV_CEN  = 3;
    localparam int EV_CERR = 4;
    localparam int EV_FERR = 5;

    typedef struct {
        int         kind;
        logic [7:0] val;
        int         lo;
        int         hi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_pin;
    logic       clr_cnt;
    logic       count_en;
    logic [7:0] quench_cfg;
    logic       quench_cfg_valid;
    logic       cmd_err;
    logic       frame_err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic prev_cen;

    uart_cmd_rx #(
        .CLK_HZ        (CLK_HZ),
        .BAUD          (BAUD),
        .QUENCH_DEFAULT(8'd10)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_pin          (rx_pin),
        .clr_cnt         (clr_cnt),
        .count_en        (count_en),
        .quench_cfg      (quench_cfg),
        .quench_cfg_valid(quench_cfg_valid),
        .cmd_err         (cmd_err),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic observe(input int kind, input logic [7:0] val);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: unexpected event kind %0d val 0x%0h at cycle %0d, expected none",
                     kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || cyc < e.lo || cyc > e.hi) begin
                n_fail++;
                $display("FAIL scoreboard: got kind %0d val 0x%0h at cycle %0d, expected kind %0d val 0x%0h in cycles %0d..%0d",
                         kind, val, cyc, e.kind, e.val, e.lo, e.hi);
            end else begin
                $display("ok   event kind %0d val 0x%0h at cycle %0d", kind, val, cyc);
            end
        end
    endtask

    // Monitor: every output pulse or count_en change must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_cen = count_en;
            end else begin
                if (clr_cnt)             observe(EV_CLR, 8'h00);
                if (quench_cfg_valid)    observe(EV_QCFG, quench_cfg);
                if (count_en != prev_cen) observe(EV_CEN, {7'b0, count_en});
                if (cmd_err)             observe(EV_CERR, 8'h00);
                if (frame_err)           observe(EV_FERR, 8'h00);
                prev_cen = count_en;
                while (exp_q.size() > 0 && exp_q[0].hi < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard: event kind %0d val 0x%0h not seen by cycle %0d",
                             exp_q[0].kind, exp_q[0].val, exp_q[0].hi);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Serial frame, LSB first; an expected event is anchored to the start-bit edge.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int kind, input logic [7:0] val);
        logic [9:0] frame;
        exp_t       e;
        frame = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        if (kind != EV_NONE) begin
            e.kind = kind;
            e.val  = val;
            e.lo   = cyc + NOM - 6;
            e.hi   = cyc + NOM + 10;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            rx_pin = frame[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_pin = 1'b1;
        repeat (IDLE_GAP) @(posedge clk);
    endtask

    task automatic send_str(input string s, input int kind, input logic [7:0] val);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1, (i == s.len() - 1) ? kind : EV_NONE, val);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " clr_cnt"}, clr_cnt, 0);
        check({tag, " count_en"}, count_en, 1);
        check({tag, " quench_cfg"}, quench_cfg, 8'h0A);
        check({tag, " quench_cfg_valid"}, quench_cfg_valid, 0);
        check({tag, " cmd_err"}, cmd_err, 0);
        check({tag, " frame_err"}, frame_err, 0);
    endtask

    initial begin
        rst    = 1'b1;
        rx_pin = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // Clear command
        send_str("#R\015", EV_CLR, 8'h00);
        #1;
        check("count_en after R", count_en, 1);

        // Quench load with lowercase hex, then stop / go
        send_str("#Q3a\015", EV_QCFG, 8'h3A);
        #1;
        check("quench_cfg after Q3a", quench_cfg, 8'h3A);
        send_str("#S\015", EV_CEN, 8'h00);
        #1;
        check("count_en after S", count_en, 0);
        send_str("#G\015", EV_CEN, 8'h01);

        // 100-cycle low glitch must be rejected silently
        @(posedge clk);
        #1;
        rx_pin = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rx_pin = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        send_str("#R\015", EV_CLR, 8'h00);

        // Bad stop bit mid-frame aborts the parser without cmd_err
        send_str("#Q3", EV_NONE, 8'h00);
        send_byte(8'h41, 1'b0, EV_FERR, 8'h00);
        send_str("A\015", EV_NONE, 8'h00);
        #1;
        check("quench_cfg after frame_err", quench_cfg, 8'h3A);

        // Unknown command, then '#' restart inside a frame
        send_str("#X", EV_CERR, 8'h00);
        send_byte(8'h0D, 1'b1, EV_NONE, 8'h00);
        send_str("#Q#R\015", EV_CLR, 8'h00);

        // Reset during the data bits of 'Q'
        send_byte(8'h23, 1'b1, EV_NONE, 8'h00);
        fork
            send_byte(8'h51, 1'b1, EV_NONE, 8'h00);
            begin
                repeat (4 * CPB) @(posedge clk);
                #1;
                rst = 1'b1;
            end
        join
        #1;
        check_reset_values("mid-byte reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        send_str("#R\015", EV_CLR, 8'h00);

        repeat (2 * CPB) @(posedge clk);
        #1;
        check("pending expectations", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 434 at defaults).
REQ-003 Parameter QUENCH_DEFAULT, default 8'd10, quench-width value loaded at reset.
REQ-004 clk  input  1  system clock, 50 MHz; sole clock of the block.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 rx_pin  input  1  UART receive line from PC; asynchronous; idles high.
REQ-007 clr_cnt  output  1  one-cycle pulse requesting the pulse counter be cleared.
REQ-008 count_en  output  1  level; 1 = counting enabled.
REQ-009 quench_cfg  output  8  quench pulse width in clk cycles.
REQ-010 quench_cfg_valid  output  1  one-cycle pulse when quench_cfg is updated.
REQ-011 cmd_err  output  1  one-cycle pulse on a malformed command.
REQ-012 frame_err  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-013 rx_pin SHALL pass through a two-flop synchronizer before any use; a falling edge is detected on the synchronized signal.
REQ-014 The byte receiver SHALL use states IDLE, START, DATA, STOP, and SHALL use 8N1 framing with LSB first.
REQ-015 IDLE -> START on a synchronized falling edge.
REQ-016 START -> DATA if the line is still 0 at CLKS_PER_BIT/2 cycles (217); otherwise START -> IDLE, with no output (glitch rejection).
REQ-017 DATA SHALL sample one bit every CLKS_PER_BIT cycles, counted from the mid-start sample; after 8 bits, DATA -> STOP.
REQ-018 STOP SHALL sample one bit period after the last data bit.
REQ-019 If the stop sample is 1, an internal byte-valid pulse SHALL assert for one cycle, the cycle after the sample.
REQ-020 If the stop sample is 0, frame_err SHALL pulse for one cycle and the byte SHALL be discarded.
REQ-021 After STOP the receiver SHALL return to IDLE; a new start bit requires a fresh falling edge.
REQ-022 The parser SHALL use states P_IDLE, P_CMD, P_H1, P_H2, P_END, and SHALL act only on valid bytes.
REQ-023 P_IDLE waits for '#' (0x23) -> P_CMD.
REQ-024 In P_CMD: 'R', 'S' or 'G' -> P_END with the command latched; 'Q' -> P_H1; any other byte -> cmd_err, P_IDLE.
REQ-025 P_H1 and P_H2 SHALL accept hex digits 0-9, A-F and a-f; the first digit is the high nibble.
REQ-026 A non-hex byte in P_H1 or P_H2 SHALL pulse cmd_err and return to P_IDLE.
REQ-027 P_END SHALL accept CR (0x0D) to execute the latched command; any other byte -> cmd_err, P_IDLE.
REQ-028 '#' received in any state other than P_IDLE SHALL restart the frame (-> P_CMD) without cmd_err.
REQ-029 A frame_err SHALL abort the parser to P_IDLE without cmd_err.
REQ-030 Executing 'R' SHALL pulse clr_cnt for one cycle.
REQ-031 Executing 'S' SHALL set count_en to 0.
REQ-032 Executing 'G' SHALL set count_en to 1.
REQ-033 Executing 'Q' SHALL load the assembled byte into quench_cfg and pulse quench_cfg_valid for one cycle.
REQ-034 All outputs SHALL be registered; command outputs and cmd_err assert exactly 1 cycle after the byte-valid pulse of the triggering byte.
REQ-035 Bytes received while the parser is in P_IDLE other than '#' SHALL be ignored silently.

Reset
REQ-036 On rst: receiver in IDLE, parser in P_IDLE, synchronizer flops 1, all counters 0.
REQ-037 On rst: clr_cnt, quench_cfg_valid, cmd_err and frame_err 0; count_en 1; quench_cfg QUENCH_DEFAULT.
REQ-038 Reset asserted mid-byte or mid-frame SHALL discard partial data, with no output pulse during or after reset.

Structure
REQ-039 Package uart_cmd_pkg SHALL hold CLKS_PER_BIT, the ASCII constants ('#', 'R', 'S', 'G', 'Q', CR) and both state enumerations.
REQ-040 Byte reception SHALL be the sub-module uart_rx_byte (outputs: 8-bit data, byte_valid, frame_err); parsing stays in uart_cmd_rx.

Verification
REQ-041 Drive "#R\r" at 115200 -> one clr_cnt pulse 1 cycle after the CR byte-valid; count_en stays 1.
REQ-042 Drive "#Q3a\r" -> quench_cfg = 0x3A with one quench_cfg_valid pulse; then "#S\r" -> count_en 0, then "#G\r" -> count_en 1.
REQ-043 Drive a 100-cycle low glitch on rx_pin -> no byte, no frame_err; a following "#R\r" still clears.
REQ-044 Drive a byte with stop bit 0 mid-frame ("#Q3" then a bad byte, then "A\r") -> one frame_err, no cmd_err, no quench update.
REQ-045 Drive "#X\r" -> one cmd_err; drive "#Q#R\r" -> one clr_cnt, no cmd_err.
REQ-046 Assert rst during the DATA bits of 'Q' -> all outputs at reset values; the next "#R\r" executes normally.
